// File: rtl/instruction_fetch_if.sv
// Fetch-unit bundle: PC handshake, program-memory read port, decoder handshake
// and the flush/halt/error control lines.
interface instruction_fetch_if #(
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0]  pc_value;
  logic                   pc_enOut;
  logic                   pc_inc;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic                   mem_rd_en;
  logic [INSTR_WIDTH-1:0] mem_data;
  logic                   mem_data_valid;
  logic [INSTR_WIDTH-1:0] ir_out;
  logic                   ir_valid;
  logic                   ir_ready;
  logic                   flush;
  logic                   halt;
  logic                   fetch_error;

  modport master (
    input  pc_value, mem_data, mem_data_valid, ir_ready, flush, halt,
    output pc_enOut, pc_inc, mem_addr, mem_rd_en, ir_out, ir_valid, fetch_error
  );

  modport slave (
    output pc_value, mem_data, mem_data_valid, ir_ready, flush, halt,
    input  pc_enOut, pc_inc, mem_addr, mem_rd_en, ir_out, ir_valid, fetch_error
  );
endinterface

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch: samples the PC, strobes program memory,
// latches the returned word and hands it to the decoder with valid/ready.
module instruction_fetch #(
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH = 16,
  parameter int TIMEOUT     = 16
) (
  input  logic                clk,
  input  logic                rst,
  instruction_fetch_if.master bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;

  localparam int            TW         = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  logic [2:0]             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q,  addr_d;
  logic [INSTR_WIDTH-1:0] ir_q,    ir_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   rd_q,    rd_d;
  logic                   inc_q,   inc_d;
  logic                   timed_out;

  assign timed_out = (timer_q == TIMER_LAST);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    timer_d = timer_q;
    rd_d    = 1'b0;
    inc_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!bus.halt && !bus.flush) state_d = S_REQ;
      end
      S_REQ: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          addr_d  = bus.pc_value;
          rd_d    = 1'b1;
          timer_d = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.flush && bus.mem_data_valid) begin
          state_d = S_IDLE;
        end else if (bus.flush) begin
          state_d = S_DRAIN;
        end else if (bus.mem_data_valid) begin
          ir_d    = bus.mem_data;
          inc_d   = 1'b1;
          state_d = S_HOLD;
        end else if (timed_out) begin
          state_d = S_ERROR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else if (bus.ir_ready) begin
          state_d = bus.halt ? S_IDLE : S_REQ;
        end
      end
      // The abandoned read still owes us a response; swallow it before refetching.
      S_DRAIN: begin
        if (bus.mem_data_valid) begin
          state_d = S_IDLE;
        end else if (timed_out) begin
          state_d = S_ERROR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
    // Error state presents nothing but the flag, so clear the datapath regs.
    if (state_d == S_ERROR) begin
      addr_d = '0;
      ir_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      ir_q    <= '0;
      timer_q <= '0;
      rd_q    <= 1'b0;
      inc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      timer_q <= timer_d;
      rd_q    <= rd_d;
      inc_q   <= inc_d;
    end
  end

  // A jump in the same cycle must win over the increment.
  assign bus.pc_inc      = inc_q & ~bus.flush;
  assign bus.pc_enOut    = (state_q == S_REQ);
  assign bus.mem_addr    = addr_q;
  assign bus.mem_rd_en   = rd_q;
  assign bus.ir_out      = ir_q;
  assign bus.ir_valid    = (state_q == S_HOLD);
  assign bus.fetch_error = (state_q == S_ERROR);

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus a randomized run checked
// against a transaction-level model of PC, memory and decoder.
module tb_instruction_fetch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instruction_fetch_if #(.ADDR_WIDTH(8), .INSTR_WIDTH(16)) bus ();

  instruction_fetch #(.ADDR_WIDTH(8), .INSTR_WIDTH(16), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  pc_drv;
  logic        s_en, s_inc, s_rd, s_irv, s_err;
  logic [7:0]  s_addr;
  logic [15:0] s_ir;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic sample();
    s_en   = bus.pc_enOut;
    s_inc  = bus.pc_inc;
    s_addr = bus.mem_addr;
    s_rd   = bus.mem_rd_en;
    s_ir   = bus.ir_out;
    s_irv  = bus.ir_valid;
    s_err  = bus.fetch_error;
  endtask

  task automatic tick(input logic vld, input logic [15:0] d, input logic rdy,
                      input logic fl, input logic hl);
    @(negedge clk);
    bus.mem_data_valid = vld;
    bus.mem_data       = d;
    bus.ir_ready       = rdy;
    bus.flush          = fl;
    bus.halt           = hl;
    bus.pc_value       = pc_drv;
    #1;
    sample();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pc_enOut"},    32'(s_en),   32'd0);
    chk({tag, "_pc_inc"},      32'(s_inc),  32'd0);
    chk({tag, "_mem_addr"},    32'(s_addr), 32'd0);
    chk({tag, "_mem_rd_en"},   32'(s_rd),   32'd0);
    chk({tag, "_ir_out"},      32'(s_ir),   32'd0);
    chk({tag, "_ir_valid"},    32'(s_irv),  32'd0);
    chk({tag, "_fetch_error"}, 32'(s_err),  32'd0);
  endtask

  // Assert reset between clock edges, check the outputs clear at once, release halted.
  task automatic pulse_reset(input string tag);
    #1;
    rst = 1'b1;
    #1;
    sample();
    chk_all_zero(tag);
    @(negedge clk);
    bus.halt           = 1'b1;
    bus.flush          = 1'b0;
    bus.mem_data_valid = 1'b0;
    bus.ir_ready       = 1'b0;
    rst                = 1'b0;
  endtask

  task automatic wait_strobe(input string tag, input logic [7:0] exp_addr);
    logic prev_en;
    bit   found;
    found   = 1'b0;
    prev_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      prev_en = s_en;
      tick(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      if (s_rd) begin
        found = 1'b1;
        break;
      end
    end
    chk({tag, "_strobe_seen"},  32'(found),    32'd1);
    chk({tag, "_pc_en_before"}, 32'(prev_en),  32'd1);
    chk({tag, "_mem_addr"},     32'(s_addr),   32'(exp_addr));
    chk({tag, "_pc_en_in_wait"}, 32'(s_en),    32'd0);
  endtask

  task automatic do_fetch(input string tag, input logic [7:0] exp_addr, input logic [15:0] word,
                          input int lat, input int hold_n, input logic halt_after);
    int incs;
    incs = 0;
    wait_strobe(tag, exp_addr);
    for (int i = 1; i < lat; i++) begin
      tick(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      chk({tag, "_rd_en_once"}, 32'(s_rd),  32'd0);
      chk({tag, "_irv_early"},  32'(s_irv), 32'd0);
    end
    tick(1'b1, word, 1'b0, 1'b0, 1'b0);
    chk({tag, "_irv_same_cycle"}, 32'(s_irv), 32'd0);
    for (int h = 0; h <= hold_n; h++) begin
      if (h < hold_n) tick(1'b1, ~word, 1'b0, 1'b0, 1'b0);
      else            tick(1'b0, 16'h0, 1'b1, 1'b0, halt_after);
      chk({tag, "_ir_valid"},   32'(s_irv), 32'd1);
      chk({tag, "_ir_out"},     32'(s_ir),  32'(word));
      chk({tag, "_no_restrobe"}, 32'(s_rd), 32'd0);
      chk({tag, "_pc_inc"},     32'(s_inc), 32'(h == 0));
      if (s_inc) begin
        incs++;
        pc_drv = pc_drv + 8'd1;
      end
    end
    chk({tag, "_pc_inc_count"}, 32'(incs), 32'd1);
    tick(1'b0, 16'h0, 1'b0, 1'b0, halt_after);
    chk({tag, "_irv_dropped"}, 32'(s_irv), 32'd0);
    chk({tag, "_inc_dropped"}, 32'(s_inc), 32'd0);
    chk({tag, "_next_req"},    32'(s_en),  32'(!halt_after));
  endtask

  // Randomized-run model state
  logic [15:0] memw [256];
  logic [7:0]  pc_m, req_addr;
  logic [15:0] exp_ir, r_data;
  logic        r_vld, r_fl, r_rdy, r_hl;
  bit          outst, dropped, hold_m, pend_inc, counted;
  int          resp_cnt, nstrobe, naccept;

  initial begin
    bus.pc_value       = 8'h00;
    bus.mem_data       = 16'h0;
    bus.mem_data_valid = 1'b0;
    bus.ir_ready       = 1'b0;
    bus.flush          = 1'b0;
    bus.halt           = 1'b1;
    pc_drv             = 8'h00;

    @(negedge clk);
    #1;
    sample();
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // T1 normal fetch, then T2 backpressure with spurious valid during HOLD
    pc_drv = 8'hCC;
    do_fetch("T1", 8'hCC, 16'hA55A, 2, 0, 1'b0);
    do_fetch("T2", 8'hCD, 16'hA55A, 1, 5, 1'b1);

    // T3 flush in WAIT, data arrives in DRAIN and is dropped
    pc_drv = 8'h40;
    wait_strobe("T3", 8'h40);
    tick(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    chk("T3_irv_flush", 32'(s_irv), 32'd0);
    chk("T3_inc_flush", 32'(s_inc), 32'd0);
    pc_drv = 8'h10;
    tick(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0);
    chk("T3_irv_drain", 32'(s_irv), 32'd0);
    chk("T3_inc_drain", 32'(s_inc), 32'd0);
    chk("T3_rd_drain",  32'(s_rd),  32'd0);
    tick(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    chk("T3_irv_idle", 32'(s_irv), 32'd0);
    chk("T3_inc_idle", 32'(s_inc), 32'd0);
    chk("T3_en_idle",  32'(s_en),  32'd0);
    do_fetch("T3n", 8'h10, 16'h1357, 1, 0, 1'b1);

    // T4 timeout: 16 WAIT cycles without data
    pc_drv = 8'h20;
    wait_strobe("T4", 8'h20);
    for (int i = 1; i < 16; i++) begin
      tick(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      chk("T4_no_err_yet", 32'(s_err), 32'd0);
    end
    tick(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("T4_err_set", 32'(s_err), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 16'hFFFF, 1'b1, (i == 1), 1'b0);
      chk("T4_err_sticky", 32'(s_err),  32'd1);
      chk("T4_err_en",     32'(s_en),   32'd0);
      chk("T4_err_rd",     32'(s_rd),   32'd0);
      chk("T4_err_irv",    32'(s_irv),  32'd0);
      chk("T4_err_addr",   32'(s_addr), 32'd0);
      chk("T4_err_ir",     32'(s_ir),   32'd0);
      chk("T4_err_inc",    32'(s_inc),  32'd0);
    end
    pulse_reset("T4_rst");
    tick(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    chk("T4_idle_en",  32'(s_en),  32'd0);
    chk("T4_idle_err", 32'(s_err), 32'd0);

    // T5 async reset in the middle of a WAIT cycle
    pc_drv = 8'h30;
    wait_strobe("T5", 8'h30);
    pulse_reset("T5_rst");
    pc_drv = 8'h31;
    do_fetch("T5b", 8'h31, 16'h7E57, 3, 0, 1'b1);

    // T6 address wrap, then halt stops fetching
    pc_drv = 8'hFF;
    do_fetch("T6a", 8'hFF, 16'h0F0F, 1, 0, 1'b0);
    do_fetch("T6b", 8'h00, 16'hF0F0, 2, 0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 16'h5555, 1'b1, 1'b0, 1'b1);
      chk("T6_halt_rd",  32'(s_rd),  32'd0);
      chk("T6_halt_en",  32'(s_en),  32'd0);
      chk("T6_halt_irv", 32'(s_irv), 32'd0);
    end

    // Randomized run: bench plays PC, memory (latency 1..4) and decoder
    pulse_reset("R_rst");
    for (int i = 0; i < 256; i++) memw[i] = 16'($urandom);
    pc_m     = 8'($urandom);
    outst    = 1'b0;
    dropped  = 1'b0;
    hold_m   = 1'b0;
    pend_inc = 1'b0;
    exp_ir   = 16'h0;
    req_addr = 8'h0;
    resp_cnt = 0;
    nstrobe  = 0;
    naccept  = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      pc_drv = pc_m;
      r_vld  = outst && (resp_cnt == 0);
      r_data = r_vld ? memw[req_addr] : 16'($urandom);
      r_fl   = ($urandom_range(0, 99) < 5);
      r_rdy  = ($urandom_range(0, 99) < 60);
      r_hl   = ($urandom_range(0, 99) < 10);
      tick(r_vld, r_data, r_rdy, r_fl, r_hl);

      chk("R_pc_inc",   32'(s_inc), 32'(pend_inc && !r_fl));
      chk("R_ir_valid", 32'(s_irv), 32'(hold_m));
      if (hold_m) chk("R_ir_out", 32'(s_ir), 32'(exp_ir));
      chk("R_no_error", 32'(s_err), 32'd0);
      if (s_rd) begin
        chk("R_single_outstanding", 32'(outst), 32'd0);
        chk("R_fetch_addr", 32'(s_addr), 32'(pc_m));
        outst    = 1'b1;
        dropped  = 1'b0;
        req_addr = s_addr;
        resp_cnt = int'($urandom_range(1, 4)) - 1;
        nstrobe++;
      end else if (outst) begin
        resp_cnt--;
      end

      if (r_fl) dropped = 1'b1;
      counted = 1'b0;
      if (r_vld) begin
        counted = !dropped;
        outst   = 1'b0;
      end
      if (counted) begin
        hold_m = 1'b1;
        exp_ir = r_data;
        naccept++;
      end else if (hold_m && (r_fl || r_rdy)) begin
        hold_m = 1'b0;
      end
      if (r_fl)          pc_m = 8'($urandom);
      else if (pend_inc) pc_m = pc_m + 8'd1;
      pend_inc = counted;
    end
    chk("R_enough_strobes", 32'(nstrobe >= 100), 32'd1);
    chk("R_enough_words",   32'(naccept >= 50),  32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
